// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future receive path).
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded bit period in clock cycles.
  function automatic int clks_per_bit(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; head word is visible on rd_data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_push  = wr_en && !r_full;
  assign w_pop   = rd_en && !r_empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + 1'b1;
          r_empty <= 1'b0;
          r_full  <= (r_count == LAST);
        end
        2'b01: begin
          r_count <= r_count - 1'b1;
          r_full  <= 1'b0;
          r_empty <= (r_count == ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with configurable frame format and zero-gap back-to-back frames.
// Optional flow control: define UART_TX_CTS_EN to add the cts_n input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam int STOP_CLKS = STOP_BITS * CPB;
  localparam int CW        = $clog2(STOP_CLKS);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_CLKS - 1);
  localparam logic [3:0]    DB_END   = 4'(DATA_BITS - 1);

  state_t                 r_state;
  logic [CW-1:0]          r_baud;
  logic [3:0]             r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_full, w_empty, w_pop, w_cts_ok, w_par;

`ifdef UART_TX_CTS_EN
  logic r_cts_s1, r_cts_s2;
  // Resets to "not clear" so nothing leaves before the line has been sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
    end else begin
      r_cts_s1 <= cts_n;
      r_cts_s2 <= r_cts_s1;
    end
  end
  assign w_cts_ok = !r_cts_s2;
`else
  assign w_cts_ok = 1'b1;
`endif

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  // Pop only where a new frame may begin: from IDLE, or on the last stop-bit cycle.
  assign w_pop = !w_empty && w_cts_ok &&
                 ((r_state == IDLE) || (r_state == STOP && r_baud == STOP_END));
  assign w_par = (^w_head) ^ (PARITY == PAR_ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_state <= START;
            r_shift <= w_head;
            r_par   <= w_par;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          r_baud <= r_baud + 1'b1;
          if (r_baud == BIT_END) begin
            r_state <= DATA;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        DATA: begin
          r_baud <= r_baud + 1'b1;
          if (r_baud == BIT_END) begin
            r_baud <= '0;
            if (r_bit == DB_END) begin
              if (PARITY != PAR_NONE) begin
                r_state <= PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        PAR: begin
          r_baud <= r_baud + 1'b1;
          if (r_baud == BIT_END) begin
            r_state <= STOP;
            r_baud  <= '0;
            r_tx    <= 1'b1;
          end
        end
        STOP: begin
          r_baud <= r_baud + 1'b1;
          if (r_baud == STOP_END) begin
            r_baud <= '0;
            if (w_pop) begin
              r_state <= START;
              r_shift <= w_head;
              r_par   <= w_par;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready = !w_full;
  assign uart_tx  = r_tx;
  assign busy     = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 depth-4 instance plus 7E2 / 7O2 instances, 4 clocks per bit.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy;
  logic [2:0] a_count;
  logic [6:0] p_data = '0;
  logic       p_valid = 1'b0;
  logic       b_ready, b_tx, b_busy, c_ready, c_tx, c_busy;
  logic [4:0] b_count, c_count;
`ifdef UART_TX_CTS_EN
  logic       a_cts_n = 1'b0;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(12_000_000), .BAUD(3_000_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid),
`ifdef UART_TX_CTS_EN
    .cts_n(a_cts_n),
`endif
    .tx_ready(a_ready), .uart_tx(a_tx), .busy(a_busy), .fifo_count(a_count));

  uart_tx_fifo #(.CLK_FREQ(12_000_000), .BAUD(3_000_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .tx_data(p_data), .tx_valid(p_valid),
`ifdef UART_TX_CTS_EN
    .cts_n(1'b0),
`endif
    .tx_ready(b_ready), .uart_tx(b_tx), .busy(b_busy), .fifo_count(b_count));

  uart_tx_fifo #(.CLK_FREQ(12_000_000), .BAUD(3_000_000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .rst(rst), .tx_data(p_data), .tx_valid(p_valid),
`ifdef UART_TX_CTS_EN
    .cts_n(1'b0),
`endif
    .tx_ready(c_ready), .uart_tx(c_tx), .busy(c_busy), .fifo_count(c_count));

  // Line level t cycles into a frame (4 cycles per bit): start, data LSB first, parity, stop.
  function automatic logic exp_bit(input logic [8:0] w, input int nb, input bit hp,
                                   input logic pb, input int t);
    int b;
    b = t / 4;
    if (b == 0) return 1'b0;
    if (b <= nb) return w[b-1];
    if (hp && b == nb + 1) return pb;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (a_tx !== 1'b1) begin n_fail++; $display("FAIL reset_a_tx: got %b want 1", a_tx); end
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
    n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
    n_chk++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_a_count: got %0d want 0", a_count); end
    n_chk++; if (b_tx !== 1'b1 || c_tx !== 1'b1) begin n_fail++; $display("FAIL reset_bc_tx: got %b%b want 11", b_tx, c_tx); end
    n_chk++; if (b_busy !== 1'b0 || c_count !== 5'd0) begin n_fail++; $display("FAIL reset_bc_state: busy %b count %0d want 0 0", b_busy, c_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_8n1_single;
    int t;
    logic e;
    @(posedge clk); #1;
    a_data = 8'hA5; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = 8'h00;
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      t = k - 2;
      e = (t >= 0 && t < 40) ? exp_bit(9'h0A5, 8, 1'b0, 1'b0, t) : 1'b1;
      n_chk++; if (a_tx !== e) begin n_fail++; $display("FAIL single_line t=%0d: got %b want %b", t, a_tx, e); end
      n_chk++; if (a_busy !== (t < 40)) begin n_fail++; $display("FAIL single_busy t=%0d: got %b want %b", t, a_busy, t < 40); end
      if (k == 1) begin
        n_chk++; if (a_count !== 3'd1) begin n_fail++; $display("FAIL single_count_push: got %0d want 1", a_count); end
      end
      if (k == 2) begin
        n_chk++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL single_count_pop: got %0d want 0", a_count); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w [3];
    int t, peak;
    logic e;
    w = '{8'h01, 8'h02, 8'h03};
    peak = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a_data = w[i]; a_valid = 1'b1;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    for (int k = 3; k <= 123; k++) begin
      @(negedge clk);
      t = k - 2;
      if (int'(a_count) > peak) peak = int'(a_count);
      e = (t < 120) ? exp_bit({1'b0, w[t / 40]}, 8, 1'b0, 1'b0, t % 40) : 1'b1;
      n_chk++; if (a_tx !== e) begin n_fail++; $display("FAIL b2b_line t=%0d: got %b want %b", t, a_tx, e); end
      if (k == 3) begin
        n_chk++; if (a_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", a_count); end
      end
    end
    n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", a_busy); end
    n_chk++; if (peak != 2) begin n_fail++; $display("FAIL b2b_peak: got %0d want 2", peak); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] w [6];
    int n, t;
    logic r, e;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    n = 0;
    @(posedge clk); #1;
    a_data = w[0]; a_valid = 1'b1;
    for (int it = 0; it <= 205; it++) begin
      @(negedge clk);
      t = it - 2;
      e = (t >= 0 && t < 200) ? exp_bit({1'b0, w[t / 40]}, 8, 1'b0, 1'b0, t % 40) : 1'b1;
      n_chk++; if (a_tx !== e) begin n_fail++; $display("FAIL full_line t=%0d: got %b want %b", t, a_tx, e); end
      n_chk++; if (a_ready !== (it < 5 || it >= 42)) begin n_fail++; $display("FAIL full_ready it=%0d: got %b want %b", it, a_ready, it < 5 || it >= 42); end
      n_chk++; if (a_busy !== (it >= 1 && t < 200)) begin n_fail++; $display("FAIL full_busy it=%0d: got %b", it, a_busy); end
      if (it == 30) begin
        n_chk++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", a_count); end
      end
      r = a_ready;
      @(posedge clk);
      if (a_valid && r) n++;
      #1;
      a_data = w[(n < 6) ? n : 5];
      if (it == 30) a_valid = 1'b0;
    end
    n_chk++; if (n != 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", n); end
  endtask

  task automatic test_parity;
    int t;
    logic eb, ec;
    @(posedge clk); #1;
    p_data = 7'h55; p_valid = 1'b1;
    @(posedge clk); #1;
    p_valid = 1'b0; p_data = 7'h00;
    for (int k = 1; k <= 47; k++) begin
      @(negedge clk);
      t = k - 2;
      eb = (t >= 0 && t < 44) ? exp_bit(9'h055, 7, 1'b1, 1'b0, t) : 1'b1;
      ec = (t >= 0 && t < 44) ? exp_bit(9'h055, 7, 1'b1, 1'b1, t) : 1'b1;
      n_chk++; if (b_tx !== eb) begin n_fail++; $display("FAIL even_line t=%0d: got %b want %b", t, b_tx, eb); end
      n_chk++; if (c_tx !== ec) begin n_fail++; $display("FAIL odd_line t=%0d: got %b want %b", t, c_tx, ec); end
      n_chk++; if (b_busy !== (t < 44) || c_busy !== (t < 44)) begin n_fail++; $display("FAIL parity_busy t=%0d: got %b%b want %b", t, b_busy, c_busy, t < 44); end
      if (t == 34) begin
        n_chk++; if (b_tx !== 1'b0 || c_tx !== 1'b1) begin n_fail++; $display("FAIL parity_bit: got even %b odd %b want 0 1", b_tx, c_tx); end
      end
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a_data = 8'hF0; a_valid = 1'b1;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    repeat (16) @(negedge clk);
    n_chk++; if (a_tx !== 1'b0 || a_count !== 3'd2) begin n_fail++; $display("FAIL mid_pre: tx %b count %0d want 0 2", a_tx, a_count); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (a_tx !== 1'b1) begin n_fail++; $display("FAIL mid_tx: got %b want 1", a_tx); end
    n_chk++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", a_count); end
    n_chk++; if (a_busy !== 1'b0 || a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_flags: busy %b ready %b want 0 1", a_busy, a_ready); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n_chk++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_quiet k=%0d: tx %b busy %b want 1 0", k, a_tx, a_busy); end
    end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts;
    logic e;
    a_cts_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    a_data = 8'h3C; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_chk++; if (a_tx !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL cts_hold k=%0d: tx %b busy %b want 1 1", k, a_tx, a_busy); end
    end
    @(posedge clk); #1;
    a_cts_n = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_chk++; if (a_tx !== (j < 3)) begin n_fail++; $display("FAIL cts_latency j=%0d: got %b want %b", j, a_tx, j < 3); end
    end
    for (int t = 1; t <= 41; t++) begin
      @(negedge clk);
      if (t == 10) a_cts_n = 1'b1;
      e = (t < 40) ? exp_bit(9'h03C, 8, 1'b0, 1'b0, t) : 1'b1;
      n_chk++; if (a_tx !== e) begin n_fail++; $display("FAIL cts_frame t=%0d: got %b want %b", t, a_tx, e); end
    end
    n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL cts_busy_end: got %b want 0", a_busy); end
    a_cts_n = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_8n1_single();
    test_back_to_back();
    test_fifo_full();
    test_parity();
    test_reset_mid();
`ifdef UART_TX_CTS_EN
    repeat (4) @(posedge clk);
    test_cts();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised, buffered UART transmitter; successor to the fixed 8N1 transmitter that drives UART_TX in the display/button top level.
- Accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first.
- Frame format is configurable: data width, parity mode and stop bits.
- Back-to-back frames are sent with no idle gap, so display and status logic can burst messages without stalling.

Parameters:
- CLK_FREQ, 12_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s. Bit period CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD; must be ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a word; equals !full.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- cts_n  in  1  clear-to-send, active low; port exists only with UART_TX_CTS_EN.

Behaviour:
- Reset, on a clk edge with rst=1:
  - uart_tx=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM goes to IDLE; FIFO pointers cleared; baud and bit counters cleared.
  - Reset mid-frame aborts the frame; uart_tx is high from the next edge.
- Handshake:
  - A word is written on an edge where tx_valid && tx_ready.
  - tx_ready is registered from occupancy at the start of the cycle. When full, a simultaneous pop does not allow a same-cycle push.
  - tx_valid while tx_ready=0 is ignored; the word is dropped and no flag is raised. The producer must hold the word.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START: on the edge where the FIFO is non-empty. The head word is popped into the shift register and uart_tx=0 from that edge.
  - Latency: the start bit begins exactly 1 cycle after the accepting edge of a word written into an empty, idle block.
  - Each state lasts CLKS_PER_BIT cycles, counted by a baud counter that is reset on every state entry.
  - START → DATA.
  - DATA: DATA_BITS bits, LSB first, shifting right.
  - DATA → PAR when PARITY≠0, else DATA → STOP.
  - PAR: the bit is the XOR of the data bits; inverted for odd parity.
  - STOP: uart_tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START (zero gap); otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Simultaneous push and pop when not full: fifo_count unchanged.
- Push when empty and idle: the word is written, then popped on the following edge (no bypass path).
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_count saturates at neither end by construction.
- tx_data may change after its accepting edge; the FIFO holds the copy.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- Defined:
  - cts_n port is present, double-flop synchronised (2 cycles of latency).
  - IDLE → START and STOP → START transitions occur only when synchronised cts_n=0.
  - A frame already started always completes regardless of cts_n.
- Undefined:
  - Port absent; behaviour as if cts_n were tied 0.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PAR, STOP.
  - parity constants: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - function clks_per_bit(freq, baud).
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Registered full/empty and count.
  - Reusable by the planned RX path.

Test Plan:
All scenarios use CLK_FREQ=12_000_000 and BAUD=3_000_000 (CLKS_PER_BIT=4).
1. 8N1, push 0xA5 once → uart_tx low 1 cycle after the accept. Bits 1,0,1,0,0,1,0,1, each 4 cycles, then 4 high cycles. busy falls after 40 cycles.
2. Push 0x01, 0x02, 0x03 on consecutive cycles → fifo_count peaks at 2. Three frames are contiguous (120 cycles) with no idle bit between stop and start.
3. FIFO_DEPTH=4, hold tx_valid with the line busy → tx_ready=0 after the 5th accepted word (4 queued + 1 in the shift register). The 6th word is held off; all 5 accepted words appear on the line in order.
4. PARITY=2, STOP_BITS=2, DATA_BITS=7, push 0x55 → parity bit 0, frame 44 cycles. PARITY=1 with the same word → parity bit 1.
5. Assert rst during bit 3 of a frame with 2 words queued → next edge: uart_tx=1, fifo_count=0, busy=0. No further frame is sent.
6. UART_TX_CTS_EN: cts_n=1 with 1 word pushed → no start bit for 100 cycles. Drop cts_n → start bit appears 3 cycles later (2 sync cycles + 1). Raise cts_n mid-frame → frame completes.
